// File: rtl/rf_write_arbiter_if.sv
// Bundle of the register-file write arbiter's request, write-port and status signals.
// The master side is the pipeline/long-latency unit plus hazard unit; the slave side is the arbiter.
interface rf_write_arbiter_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             pipe_valid;
    logic [4:0]       pipe_addr;
    logic [31:0]      pipe_data;
    logic             pipe_stall;

    logic             lu_valid;
    logic             lu_ready;
    logic [4:0]       lu_addr;
    logic [31:0]      lu_data;

    logic [4:0]       wAddr;
    logic [31:0]      wDin;
    logic             wEna;

    logic [31:0]      pend_mask;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output pipe_valid, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
        input  pipe_stall, lu_ready, wAddr, wDin, wEna, pend_mask, fifo_count
    );

    modport slave (
        input  pipe_valid, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
        output pipe_stall, lu_ready, wAddr, wDin, wEna, pend_mask, fifo_count
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Sole driver of the register-file write port: merges single-cycle pipeline writeback
// with long-latency results queued in a small in-order FIFO, issuing one registered write per cycle.
module rf_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input logic              clk,
    input logic              rst_n,
    rf_write_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    // Handshake: the lu side transfers on a cycle where lu_valid && lu_ready, and lu_ready
    // looks only at current occupancy; the pipe side has no ready, it holds while pipe_stall.
    logic [4:0]            fifoAddr [FIFO_DEPTH];
    logic [31:0]           fifoData [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slotValid;
    logic [FIFO_DEPTH-1:0] slotValidNext;
    logic [PTR_W-1:0]      headPtr;
    logic [PTR_W-1:0]      tailPtr;
    logic [CNT_W-1:0]      count;
    logic [STV_W-1:0]      starveCnt;

    logic        fifoEmpty;
    logic        fifoFull;
    logic        starved;
    logic        luReady;
    logic        luAccept;
    logic        doPush;
    logic        fifoGrant;
    logic        pipeGrant;
    logic [4:0]  headAddr;
    logic [31:0] headData;
    logic [31:0] pendMask;

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == CNT_W'(FIFO_DEPTH));
    assign starved   = (starveCnt == STV_W'(STARVE_MAX));
    assign luReady   = !fifoFull;
    assign luAccept  = bus.lu_valid && luReady;
    // Results for r0 are consumed but never queued, so they cannot occupy a slot or the mask.
    assign doPush    = luAccept && (bus.lu_addr != 5'd0);

    assign fifoGrant = !fifoEmpty && (!bus.pipe_valid || fifoFull || starved);
    assign pipeGrant = bus.pipe_valid && !fifoGrant;

    assign headAddr  = fifoAddr[headPtr];
    assign headData  = fifoData[headPtr];

    assign bus.pipe_stall = bus.pipe_valid && fifoGrant;
    assign bus.lu_ready   = luReady;
    assign bus.fifo_count = count;
    assign bus.pend_mask  = pendMask;

    always_comb begin
        pendMask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slotValid[i]) begin
                pendMask = pendMask | (32'd1 << fifoAddr[i]);
            end
        end
    end

    // Head and tail only coincide when empty or full, so a push and a pop never hit the same slot.
    always_comb begin
        slotValidNext = slotValid;
        if (fifoGrant) slotValidNext[headPtr] = 1'b0;
        if (doPush)    slotValidNext[tailPtr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoAddr[tailPtr] <= bus.lu_addr;
            fifoData[tailPtr] <= bus.lu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            count     <= '0;
            slotValid <= '0;
        end else begin
            slotValid <= slotValidNext;
            if (doPush)    tailPtr <= tailPtr + PTR_W'(1);
            if (fifoGrant) headPtr <= headPtr + PTR_W'(1);
            case ({doPush, fifoGrant})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveCnt <= '0;
        end else if (fifoEmpty || fifoGrant) begin
            starveCnt <= '0;
        end else if (!starved) begin
            starveCnt <= starveCnt + STV_W'(1);
        end
    end

    // Write port: address/data hold when idle so the hazard unit can keep comparing wAddr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wAddr <= '0;
            bus.wDin  <= '0;
            bus.wEna  <= 1'b0;
        end else if (fifoGrant) begin
            bus.wAddr <= headAddr;
            bus.wDin  <= headData;
            bus.wEna  <= (headAddr != 5'd0);
        end else if (pipeGrant) begin
            bus.wAddr <= bus.pipe_addr;
            bus.wDin  <= bus.pipe_data;
            bus.wEna  <= (bus.pipe_addr != 5'd0);
        end else begin
            bus.wEna  <= 1'b0;
        end
    end

    a_no_r0_write: assert property (@(posedge clk) disable iff (!rst_n)
        bus.wEna |-> (bus.wAddr != 5'd0));
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CNT_W'(FIFO_DEPTH));
    a_slots_match: assert property (@(posedge clk) disable iff (!rst_n)
        $countones(slotValid) == int'(count));
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected writes are queued at stimulus time and a
// negedge monitor pops and compares every write the register file would see.
module tb_rf_write_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [36:0] exp_q[$];

  rf_write_arbiter_if #(.FIFO_DEPTH(4)) bus_if ();

  rf_write_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs at the negedge, settle, then screen for hazard violations
  task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    @(negedge clk);
    bus_if.pipe_valid = pv;
    bus_if.pipe_addr  = pa;
    bus_if.pipe_data  = pd;
    bus_if.lu_valid   = lv;
    bus_if.lu_addr    = la;
    bus_if.lu_data    = ld;
    #2;
    if (pv) chk("stim_hazard", {63'd0, bus_if.pend_mask[pa]}, 64'd0);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && bus_if.wEna) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write at %0t",
                 bus_if.wAddr, bus_if.wDin, $time);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({bus_if.wAddr, bus_if.wDin} !== e) begin
          errors++;
          $display("FAIL write_order: got addr %0d data %0h expected addr %0d data %0h at %0t",
                   bus_if.wAddr, bus_if.wDin, e[36:32], e[31:0], $time);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_if.pipe_valid = 1'b0;
    bus_if.pipe_addr  = '0;
    bus_if.pipe_data  = '0;
    bus_if.lu_valid   = 1'b0;
    bus_if.lu_addr    = '0;
    bus_if.lu_data    = '0;

    // reset state
    idle();
    idle();
    chk("rst_wEna", bus_if.wEna, 0);
    chk("rst_wAddr", bus_if.wAddr, 0);
    chk("rst_wDin", bus_if.wDin, 0);
    chk("rst_pend_mask", bus_if.pend_mask, 0);
    chk("rst_fifo_count", bus_if.fifo_count, 0);
    chk("rst_lu_ready", bus_if.lu_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // pipeline only
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd5, 32'hDEADBEEF);
    chk("pipe_stall_pipe_only", bus_if.pipe_stall, 0);
    idle();
    chk("pipe_wEna", bus_if.wEna, 1);
    chk("pipe_stall_after", bus_if.pipe_stall, 0);

    // idle-slot drain; write port must hold its last address while idle
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h12345678);
    expect_wr(5'd9, 32'h12345678);
    chk("hold_wEna", bus_if.wEna, 0);
    chk("hold_wAddr", bus_if.wAddr, 5);
    chk("hold_wDin", bus_if.wDin, 32'hDEADBEEF);
    chk("drain_lu_ready", bus_if.lu_ready, 1);
    idle();
    chk("drain_pend_mask_set", bus_if.pend_mask, 32'h0000_0200);
    chk("drain_count_1", bus_if.fifo_count, 1);
    idle();
    chk("drain_pend_mask_clear", bus_if.pend_mask, 0);
    chk("drain_count_0", bus_if.fifo_count, 0);

    // starvation: pipe wins 8 cycles with the entry queued, then is stalled for one
    for (int i = 0; i <= 10; i++) begin
      int k;
      k = (i <= 9) ? i : 9;
      drive(1'b1, 5'(10 + k), 32'h100 + k, (i == 0), 5'd3, 32'hA0);
      if (i < 9)       expect_wr(5'(10 + i), 32'h100 + i);
      else if (i == 9) expect_wr(5'd3, 32'hA0);
      else             expect_wr(5'd19, 32'h109);
      chk($sformatf("starve_stall_%0d", i), bus_if.pipe_stall, (i == 9));
    end
    idle();
    chk("starve_count_0", bus_if.fifo_count, 0);

    // full FIFO: four pushes under pipe traffic, a fifth held off while full
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 5'(1 + j), 32'h300 + j, 1'b1, 5'(20 + j), 32'h200 + j);
      expect_wr(5'(1 + j), 32'h300 + j);
      if (j == 3) chk("full_ready_at_3", bus_if.lu_ready, 1);
    end
    drive(1'b1, 5'd5, 32'h304, 1'b1, 5'd24, 32'h204);
    expect_wr(5'd20, 32'h200);
    chk("full_count_4", bus_if.fifo_count, 4);
    chk("full_lu_ready", bus_if.lu_ready, 0);
    chk("full_pipe_stall", bus_if.pipe_stall, 1);
    chk("full_pend_mask", bus_if.pend_mask, 32'h00F0_0000);
    drive(1'b1, 5'd5, 32'h304, 1'b1, 5'd24, 32'h204);
    expect_wr(5'd5, 32'h304);
    chk("full_count_3", bus_if.fifo_count, 3);
    chk("full_ready_again", bus_if.lu_ready, 1);
    chk("full_pipe_resume", bus_if.pipe_stall, 0);
    idle();
    expect_wr(5'd21, 32'h201);
    chk("full_count_refill", bus_if.fifo_count, 4);
    idle();
    expect_wr(5'd22, 32'h202);
    idle();
    expect_wr(5'd23, 32'h203);
    idle();
    expect_wr(5'd24, 32'h204);
    idle();
    chk("full_drained", bus_if.fifo_count, 0);

    // register 0 from both sources
    drive(1'b1, 5'd0, 32'hBAD0BAD0, 1'b1, 5'd0, 32'hBAD1BAD1);
    chk("r0_lu_ready", bus_if.lu_ready, 1);
    chk("r0_pipe_stall", bus_if.pipe_stall, 0);
    idle();
    chk("r0_wEna", bus_if.wEna, 0);
    chk("r0_count", bus_if.fifo_count, 0);
    chk("r0_pend_mask", bus_if.pend_mask, 0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD2BAD2);
    idle();
    chk("r0_lu_only_count", bus_if.fifo_count, 0);
    chk("r0_lu_only_wEna", bus_if.wEna, 0);

    // reset mid-stream with three queued entries
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 5'(25 + j), 32'h500 + j, 1'b1, 5'(28 + j), 32'h600 + j);
      expect_wr(5'(25 + j), 32'h500 + j);
    end
    idle();
    chk("mid_count_3", bus_if.fifo_count, 3);
    chk("mid_pend_mask", bus_if.pend_mask, 32'h7000_0000);
    chk("mid_wEna_before", bus_if.wEna, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wEna", bus_if.wEna, 0);
    chk("mid_rst_count", bus_if.fifo_count, 0);
    chk("mid_rst_pend_mask", bus_if.pend_mask, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) idle();
    chk("mid_post_count", bus_if.fifo_count, 0);
    chk("mid_post_wEna", bus_if.wEna, 0);

    // final report
    idle();
    chk("all_writes_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
